// File: rtl/pipelined_differencing_machine.sv
// Two-stage valid/ready decoder turning a running-sum stream
// back into its term stream (term = sum - previous sum).
module pipelined_differencing_machine (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic [31:0] sum_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [29:0] count
);

    logic [31:0] r_prev;
    logic        r_v1;
    logic [31:0] r_s1_sum;
    logic [31:0] r_s1_prev;
    logic        r_ov;
    logic [31:0] r_out;
    logic [29:0] r_count;

    logic        w_deliver;
    logic        w_s2_load;
    logic        w_accept;
    logic [31:0] w_base;

    // Handshake and stage-advance decisions.
    always_comb begin
        w_deliver = r_ov & out_ready;
        w_s2_load = r_v1 & (~r_ov | out_ready);
        in_ready  = ~r_v1 | w_s2_load;
        w_accept  = in_valid & in_ready;
        w_base    = restart ? 32'd0 : r_prev;
    end

    // Previous-sum tracker; a same-cycle accept wins over restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= 32'd0;
        end else if (w_accept) begin
            r_prev <= sum_in;
        end else if (restart) begin
            r_prev <= 32'd0;
        end
    end

    // Stage 1 holds the accepted sum and the sum it follows.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v1      <= 1'b0;
            r_s1_sum  <= 32'd0;
            r_s1_prev <= 32'd0;
        end else if (w_accept) begin
            r_v1      <= 1'b1;
            r_s1_sum  <= sum_in;
            r_s1_prev <= w_base;
        end else if (w_s2_load) begin
            r_v1      <= 1'b0;
        end
    end

    // Stage 2 computes the term and holds it under back-pressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ov  <= 1'b0;
            r_out <= 32'd0;
        end else if (w_s2_load) begin
            r_ov  <= 1'b1;
            r_out <= r_s1_sum - r_s1_prev;
        end else if (w_deliver) begin
            r_ov  <= 1'b0;
        end
    end

    // Delivered-term counter; a delivery in the restart cycle is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 30'd0;
        end else if (restart) begin
            r_count <= 30'd0;
        end else if (w_deliver) begin
            r_count <= r_count + 30'd1;
        end
    end

    assign out       = r_out;
    assign out_valid = r_ov;
    assign count     = r_count;

endmodule

// File: tb/tb_pipelined_differencing_machine.sv
// Directed, table-driven bench for pipelined_differencing_machine.
// Each row: inputs for one cycle, in_ready before the edge, outputs after it.
module tb_pipelined_differencing_machine;

    logic        clk;
    logic        reset;
    logic        restart;
    logic [31:0] sum_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] count;

    pipelined_differencing_machine dut (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .sum_in    (sum_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          rs;
        bit          iv;
        logic [31:0] sum;
        bit          ordy;
        bit          eir;
        bit          eov;
        logic [31:0] eout;
        logic [29:0] ecnt;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp;
    int   n_bad;

    task automatic add(bit rst, bit rs, bit iv, logic [31:0] sum,
                       bit ordy, bit eir, bit eov,
                       logic [31:0] eout, logic [29:0] ecnt);
        vec_t v;
        v.rst = rst; v.rs = rs; v.iv = iv; v.sum = sum;
        v.ordy = ordy; v.eir = eir; v.eov = eov;
        v.eout = eout; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        restart   = 1'b0;
        in_valid  = 1'b0;
        sum_in    = 32'd0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out", out, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_cnt", {2'd0, count}, 32'd0);
        chk("rst_ir", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
    endtask

    task automatic apply(int idx, vec_t v);
        string tag;
        tag = $sformatf("row%0d", idx);
        restart   = v.rs;
        in_valid  = v.iv;
        sum_in    = v.sum;
        out_ready = v.ordy;
        #1;
        chk({tag, "_ir"}, {31'd0, in_ready}, {31'd0, v.eir});
        @(posedge clk);
        #1;
        chk({tag, "_ov"}, {31'd0, out_valid}, {31'd0, v.eov});
        if (v.eov) chk({tag, "_out"}, out, v.eout);
        chk({tag, "_cnt"}, {2'd0, count}, {2'd0, v.ecnt});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        idle();

        // basic decode: 5,12,12,7 -> 5,7,0,-5
        add(1, 0, 1, 32'd5,  1, 1, 0, 32'd0,         30'd0);
        add(0, 0, 1, 32'd12, 1, 1, 1, 32'd5,         30'd0);
        add(0, 0, 1, 32'd12, 1, 1, 1, 32'd7,         30'd1);
        add(0, 0, 1, 32'd7,  1, 1, 1, 32'd0,         30'd2);
        add(0, 0, 0, 32'd0,  1, 1, 1, 32'hFFFFFFFB,  30'd3);
        add(0, 0, 0, 32'd0,  1, 1, 0, 32'd0,         30'd4);
        // back-pressure: 10,30 taken, 60 waits
        add(1, 0, 1, 32'd10, 0, 1, 0, 32'd0,  30'd0);
        add(0, 0, 1, 32'd30, 0, 1, 1, 32'd10, 30'd0);
        add(0, 0, 1, 32'd60, 0, 0, 1, 32'd10, 30'd0);
        add(0, 0, 1, 32'd60, 0, 0, 1, 32'd10, 30'd0);
        add(0, 0, 1, 32'd60, 1, 1, 1, 32'd20, 30'd1);
        add(0, 0, 0, 32'd0,  1, 1, 1, 32'd30, 30'd2);
        add(0, 0, 0, 32'd0,  1, 1, 0, 32'd0,  30'd3);
        // restart with a same-cycle accept of 40
        add(1, 0, 1, 32'd100, 1, 1, 0, 32'd0,   30'd0);
        add(0, 0, 1, 32'd150, 1, 1, 1, 32'd100, 30'd0);
        add(0, 1, 1, 32'd40,  1, 1, 1, 32'd50,  30'd0);
        add(0, 0, 1, 32'd45,  1, 1, 1, 32'd40,  30'd1);
        add(0, 0, 0, 32'd0,   1, 1, 1, 32'd5,   30'd2);
        add(0, 0, 0, 32'd0,   1, 1, 0, 32'd0,   30'd3);
        // modular subtract
        add(1, 0, 1, 32'hFFFFFFF0, 1, 1, 0, 32'd0,         30'd0);
        add(0, 0, 1, 32'h00000010, 1, 1, 1, 32'hFFFFFFF0,  30'd0);
        add(0, 0, 0, 32'd0,        1, 1, 1, 32'h00000020,  30'd1);
        add(0, 0, 0, 32'd0,        1, 1, 0, 32'd0,         30'd2);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            apply(i, tbl[i]);
        end

        // count wrap from a preloaded value
        do_reset();
        force dut.r_count = 30'h3FFFFFFE;
        #1;
        release dut.r_count;
        add(0, 0, 1, 32'd1, 1, 1, 0, 32'd0, 30'h3FFFFFFE);
        add(0, 0, 1, 32'd2, 1, 1, 1, 32'd1, 30'h3FFFFFFE);
        add(0, 0, 0, 32'd0, 1, 1, 1, 32'd1, 30'h3FFFFFFF);
        add(0, 0, 0, 32'd0, 1, 1, 0, 32'd0, 30'd0);
        for (int i = tbl.size() - 4; i < tbl.size(); i++) apply(i, tbl[i]);

        // asynchronous reset while two words are stalled
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sum_in    = 32'd3;
        @(posedge clk);
        #1;
        sum_in = 32'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("stall_ir", {31'd0, in_ready}, 32'd0);
        chk("stall_ov", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_ov", {31'd0, out_valid}, 32'd0);
        chk("async_cnt", {2'd0, count}, 32'd0);
        chk("async_ir", {31'd0, in_ready}, 32'd1);
        chk("async_out", out, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        add(0, 0, 1, 32'd9, 1, 1, 0, 32'd0, 30'd0);
        add(0, 0, 0, 32'd0, 1, 1, 1, 32'd9, 30'd0);
        add(0, 0, 0, 32'd0, 1, 1, 0, 32'd0, 30'd1);
        for (int i = tbl.size() - 3; i < tbl.size(); i++) apply(i, tbl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
